// File: rtl/date_editor.sv
// Date edit buffer between the pushbuttons, the date painter and the RTC write path.
// Optional hold-to-repeat on up/down is enabled by defining DATE_EDITOR_AUTOREPEAT_EN.
module date_editor #(
  parameter int unsigned ADDR_DAY  = 3,
  parameter int unsigned ADDR_MON  = 4,
  parameter int unsigned ADDR_YEAR = 5
`ifdef DATE_EDITOR_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       programar_on,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [7:0] fecha_rtc1,
  input  logic [7:0] fecha_rtc2,
  input  logic [7:0] fecha_rtc3,
  input  logic       wr_ack,
  output logic [7:0] fecha_out1,
  output logic [7:0] fecha_out2,
  output logic [7:0] fecha_out3,
  output logic [3:0] direccion_actual_pantalla,
  output logic       wr_req,
  output logic       busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StEdit   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  localparam logic [3:0] CurDay  = 4'(ADDR_DAY);
  localparam logic [3:0] CurMon  = 4'(ADDR_MON);
  localparam logic [3:0] CurYear = 4'(ADDR_YEAR);

  localparam logic [7:0] DayMin  = 8'h01;
  localparam logic [7:0] DayMax  = 8'h31;
  localparam logic [7:0] MonMin  = 8'h01;
  localparam logic [7:0] MonMax  = 8'h12;
  localparam logic [7:0] YearMin = 8'h00;
  localparam logic [7:0] YearMax = 8'h99;

  logic [1:0] state_q, state_d;
  logic [7:0] day_q, day_d, mon_q, mon_d, year_q, year_d;
  logic [3:0] cur_q, cur_d;
  logic       wr_req_q, wr_req_d;
  logic       prog_prev_q, up_prev_q, down_prev_q, left_prev_q, right_prev_q;
  logic       prog_ev, up_ev, down_ev, left_ev, right_ev;
  logic       rep_up, rep_down;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    logic [7:0] r;
    if (v == hi)                r = lo;
    else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    logic [7:0] r;
    if (v == lo)                r = hi;
    else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
    else                        r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Packed BCD compares correctly as binary once both nibbles are known to be <= 9.
  function automatic logic [7:0] sanitise(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
    logic [7:0] r;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < lo || v > hi) r = lo;
    else                                                   r = v;
    return r;
  endfunction

`ifdef DATE_EDITOR_AUTOREPEAT_EN
  logic [31:0] rep_cnt_q;
  logic        rep_armed_q, rep_dir_q;
  logic        hold_up, hold_down, holding, rep_fire;

  assign hold_up   = btn_up & ~btn_down;
  assign hold_down = btn_down & ~btn_up;
  assign holding   = (state_q == StEdit) && (hold_up || hold_down) && (hold_up == rep_dir_q);
  assign rep_fire  = holding &&
                     (rep_cnt_q == (rep_armed_q ? REPEAT_PERIOD - 1 : REPEAT_DELAY - 1));
  assign rep_up    = rep_fire & rep_dir_q;
  assign rep_down  = rep_fire & ~rep_dir_q;

  // A direction change spends one cycle re-latching the direction with the count cleared.
  always_ff @(posedge clk) begin
    if (reset || !holding) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      rep_dir_q   <= hold_up;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 32'd1;
    end
  end
`else
  assign rep_up   = 1'b0;
  assign rep_down = 1'b0;
`endif

  assign prog_ev  = programar_on & ~prog_prev_q;
  assign up_ev    = (btn_up & ~up_prev_q) | rep_up;
  assign down_ev  = (btn_down & ~down_prev_q) | rep_down;
  assign left_ev  = btn_left & ~left_prev_q;
  assign right_ev = btn_right & ~right_prev_q;

  always_comb begin
    state_d  = state_q;
    day_d    = day_q;
    mon_d    = mon_q;
    year_d   = year_q;
    cur_d    = cur_q;
    wr_req_d = wr_req_q;
    case (state_q)
      StIdle: begin
        day_d    = fecha_rtc1;
        mon_d    = fecha_rtc2;
        year_d   = fecha_rtc3;
        cur_d    = 4'd0;
        wr_req_d = 1'b0;
        if (prog_ev) begin
          state_d = StEdit;
          cur_d   = CurDay;
          day_d   = sanitise(fecha_rtc1, DayMin, DayMax);
          mon_d   = sanitise(fecha_rtc2, MonMin, MonMax);
          year_d  = sanitise(fecha_rtc3, YearMin, YearMax);
        end
      end
      StEdit: begin
        if (!programar_on) begin
          state_d  = StCommit;
          wr_req_d = 1'b1;
          cur_d    = 4'd0;
        end else if (up_ev && down_ev) begin
          // Conflicting value request: hold the field.
        end else if (up_ev) begin
          if (cur_q == CurDay)       day_d  = bcd_inc(day_q, DayMin, DayMax);
          else if (cur_q == CurMon)  mon_d  = bcd_inc(mon_q, MonMin, MonMax);
          else if (cur_q == CurYear) year_d = bcd_inc(year_q, YearMin, YearMax);
        end else if (down_ev) begin
          if (cur_q == CurDay)       day_d  = bcd_dec(day_q, DayMin, DayMax);
          else if (cur_q == CurMon)  mon_d  = bcd_dec(mon_q, MonMin, MonMax);
          else if (cur_q == CurYear) year_d = bcd_dec(year_q, YearMin, YearMax);
        end else if (left_ev && right_ev) begin
          // Conflicting cursor request: hold the cursor.
        end else if (right_ev) begin
          if (cur_q == CurDay)      cur_d = CurMon;
          else if (cur_q == CurMon) cur_d = CurYear;
          else                      cur_d = CurDay;
        end else if (left_ev) begin
          if (cur_q == CurDay)      cur_d = CurYear;
          else if (cur_q == CurYear) cur_d = CurMon;
          else                      cur_d = CurDay;
        end
      end
      StCommit: begin
        wr_req_d = 1'b1;
        cur_d    = 4'd0;
        if (wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        wr_req_d = 1'b0;
        cur_d    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      day_q        <= 8'h00;
      mon_q        <= 8'h00;
      year_q       <= 8'h00;
      cur_q        <= 4'd0;
      wr_req_q     <= 1'b0;
      prog_prev_q  <= 1'b0;
      up_prev_q    <= 1'b0;
      down_prev_q  <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      day_q        <= day_d;
      mon_q        <= mon_d;
      year_q       <= year_d;
      cur_q        <= cur_d;
      wr_req_q     <= wr_req_d;
      prog_prev_q  <= programar_on;
      up_prev_q    <= btn_up;
      down_prev_q  <= btn_down;
      left_prev_q  <= btn_left;
      right_prev_q <= btn_right;
    end
  end

  assign fecha_out1                = day_q;
  assign fecha_out2                = mon_q;
  assign fecha_out3                = year_q;
  assign direccion_actual_pantalla = cur_q;
  assign wr_req                    = wr_req_q;
  assign busy                      = (state_q != StIdle);

endmodule

// File: tb/tb_date_editor.sv
// Directed bench for date_editor: capture, sanitising, BCD wrap, cursor moves and commit handshake.
module tb_date_editor;

  logic       clk = 1'b0;
  logic       reset, programar_on;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [7:0] fecha_rtc1, fecha_rtc2, fecha_rtc3;
  logic       wr_ack;
  logic [7:0] fecha_out1, fecha_out2, fecha_out3;
  logic [3:0] direccion_actual_pantalla;
  logic       wr_req, busy;

  int n_tests = 0;
  int n_fail  = 0;

  date_editor dut (
    .clk                       (clk),
    .reset                     (reset),
    .programar_on              (programar_on),
    .btn_up                    (btn_up),
    .btn_down                  (btn_down),
    .btn_left                  (btn_left),
    .btn_right                 (btn_right),
    .fecha_rtc1                (fecha_rtc1),
    .fecha_rtc2                (fecha_rtc2),
    .fecha_rtc3                (fecha_rtc3),
    .wr_ack                    (wr_ack),
    .fecha_out1                (fecha_out1),
    .fecha_out2                (fecha_out2),
    .fecha_out3                (fecha_out3),
    .direccion_actual_pantalla (direccion_actual_pantalla),
    .wr_req                    (wr_req),
    .busy                      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, so outputs are read well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse followed by a release cycle.
  task automatic press(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    tick();
  endtask

  task automatic check_date(input string tag, input logic [7:0] d, input logic [7:0] m,
                            input logic [7:0] y);
    check_eq({tag, ".day"}, fecha_out1, d);
    check_eq({tag, ".mon"}, fecha_out2, m);
    check_eq({tag, ".year"}, fecha_out3, y);
  endtask

  initial begin
    reset = 1'b1; programar_on = 1'b0; wr_ack = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    fecha_rtc1 = 8'h31; fecha_rtc2 = 8'h12; fecha_rtc3 = 8'h99;
    tick(); tick();
    check_date("rst", 8'h00, 8'h00, 8'h00);
    check_eq("rst.cur", {4'd0, direccion_actual_pantalla}, 8'd0);
    check_eq("rst.wr_req", {7'd0, wr_req}, 8'd0);
    check_eq("rst.busy", {7'd0, busy}, 8'd0);

    reset = 1'b0;
    tick();
    check_date("idle", 8'h31, 8'h12, 8'h99);
    check_eq("idle.cur", {4'd0, direccion_actual_pantalla}, 8'd0);
    check_eq("idle.busy", {7'd0, busy}, 8'd0);

    programar_on = 1'b1;
    tick();
    check_eq("enter.cur", {4'd0, direccion_actual_pantalla}, 8'd3);
    check_eq("enter.busy", {7'd0, busy}, 8'd1);
    check_date("enter", 8'h31, 8'h12, 8'h99);
    press(1, 0, 0, 0);
    check_eq("day.wrap_up", fecha_out1, 8'h01);
    press(0, 0, 0, 1);
    check_eq("cur.r3", {4'd0, direccion_actual_pantalla}, 8'd4);
    press(1, 0, 0, 0);
    check_eq("mon.wrap_up", fecha_out2, 8'h01);
    press(0, 0, 0, 1);
    check_eq("cur.r4", {4'd0, direccion_actual_pantalla}, 8'd5);
    press(1, 0, 0, 0);
    check_eq("year.wrap_up", fecha_out3, 8'h00);
    press(0, 0, 0, 1);
    check_eq("cur.r5", {4'd0, direccion_actual_pantalla}, 8'd3);
    press(0, 1, 0, 0);
    check_eq("day.wrap_dn", fecha_out1, 8'h31);
    press(0, 0, 1, 0);
    check_eq("cur.l3", {4'd0, direccion_actual_pantalla}, 8'd5);
    press(0, 1, 0, 0);
    check_eq("year.wrap_dn", fecha_out3, 8'h99);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    check_eq("mon.wrap_dn", fecha_out2, 8'h12);

    // Commit: values freeze while the RTC inputs move.
    programar_on = 1'b0;
    fecha_rtc1 = 8'h20; fecha_rtc2 = 8'h00; fecha_rtc3 = 8'h45;
    tick();
    check_eq("commit.wr_req", {7'd0, wr_req}, 8'd1);
    check_eq("commit.cur", {4'd0, direccion_actual_pantalla}, 8'd0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("commit.hold", {7'd0, wr_req}, 8'd1);
    check_eq("commit.busy", {7'd0, busy}, 8'd1);
    check_date("commit.frozen", 8'h31, 8'h12, 8'h99);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check_eq("ack.wr_req", {7'd0, wr_req}, 8'd0);
    check_eq("ack.busy", {7'd0, busy}, 8'd0);
    tick();
    check_date("idle.track", 8'h20, 8'h00, 8'h45);

    // Sanitising on load.
    fecha_rtc1 = 8'h3A;
    programar_on = 1'b1;
    tick();
    check_date("san1", 8'h01, 8'h01, 8'h45);
    programar_on = 1'b0;
    tick();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    fecha_rtc1 = 8'h20; fecha_rtc2 = 8'h13; fecha_rtc3 = 8'h9A;
    programar_on = 1'b1;
    tick();
    check_date("san2", 8'h20, 8'h01, 8'h00);

    press(0, 1, 0, 0);
    check_eq("day.borrow", fecha_out1, 8'h19);
    press(1, 0, 0, 0);
    check_eq("day.carry", fecha_out1, 8'h20);
    press(1, 1, 0, 0);
    check_eq("updn.day", fecha_out1, 8'h20);
    press(1, 0, 0, 1);
    check_eq("upright.day", fecha_out1, 8'h21);
    check_eq("upright.cur", {4'd0, direccion_actual_pantalla}, 8'd3);
    press(0, 0, 1, 1);
    check_eq("lr.cur", {4'd0, direccion_actual_pantalla}, 8'd3);

    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check_eq("ack_edit.busy", {7'd0, busy}, 8'd1);
    check_eq("ack_edit.wr_req", {7'd0, wr_req}, 8'd0);

    // programar_on raised during COMMIT is not seen as a rise back in IDLE.
    programar_on = 1'b0;
    tick();
    programar_on = 1'b1;
    tick();
    check_eq("commit_rise.busy", {7'd0, busy}, 8'd1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    tick(); tick();
    check_eq("norise.busy", {7'd0, busy}, 8'd0);
    check_eq("norise.cur", {4'd0, direccion_actual_pantalla}, 8'd0);
    programar_on = 1'b0;
    tick();
    programar_on = 1'b1;
    tick();
    check_eq("rerise.busy", {7'd0, busy}, 8'd1);

    // Reset in COMMIT drops the request.
    programar_on = 1'b0;
    tick();
    check_eq("commit2.wr_req", {7'd0, wr_req}, 8'd1);
    reset = 1'b1;
    tick();
    check_eq("rst_commit.wr_req", {7'd0, wr_req}, 8'd0);
    check_eq("rst_commit.busy", {7'd0, busy}, 8'd0);
    check_eq("rst_commit.day", fecha_out1, 8'h00);
    reset = 1'b0;
    tick();
    check_date("post_rst", 8'h20, 8'h13, 8'h9A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/date_editor.md
Name: date_editor

Overview:
- Edits the date (day, month, year) that the RTC controller writes back to the clock chip. The on-screen date digits show this edit state in programming mode.
- Captures the live RTC date, moves a cursor across the three fields, and increments or decrements each field in packed BCD with calendar wrap.
- On exit from programming mode, hands the edited date to the RTC write path over a req/ack handshake.
- Sits between the debounced pushbuttons, the date display painter (fecha_out*, direccion_actual_pantalla) and the RTC controller (wr_req/wr_ack).

Parameters:
- ADDR_DAY, 3, cursor code for the day field (fecha 1)
- ADDR_MON, 4, cursor code for the month field (fecha 2)
- ADDR_YEAR, 5, cursor code for the year field (fecha 3)
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat (optional feature only)
- REPEAT_PERIOD, 5000000, cycles between auto-repeat steps (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- programar_on  in  1  programming mode request (level)
- btn_up  in  1  debounced level: increment field
- btn_down  in  1  debounced level: decrement field
- btn_left  in  1  debounced level: cursor left
- btn_right  in  1  debounced level: cursor right
- fecha_rtc1  in  8  live day, BCD
- fecha_rtc2  in  8  live month, BCD
- fecha_rtc3  in  8  live year, BCD
- wr_ack  in  1  RTC controller has accepted the write
- fecha_out1  out  8  day to display/write, BCD
- fecha_out2  out  8  month to display/write, BCD
- fecha_out3  out  8  year to display/write, BCD
- direccion_actual_pantalla  out  4  cursor code; 0 when not editing
- wr_req  out  1  write request to the RTC controller
- busy  out  1  high in EDIT or COMMIT

Behaviour:
- Reset: all outputs are 0; state = IDLE; all edge-detect registers are 0.
- Edge detection:
  - Each button and programar_on has a registered previous value.
  - An event is input=1 while prev=0.
  - The effect is visible on the outputs at the next clock edge (1-cycle latency).
- IDLE:
  - fecha_outN <= fecha_rtcN every cycle. Cursor = 0, wr_req = 0.
  - On a programar_on rise: go to EDIT, cursor <= ADDR_DAY, and load the shadow registers from fecha_rtcN with sanitising.
- Sanitising (applied only on load):
  - A field with any nibble > 9, or outside its legal range, loads its minimum.
  - Day range is 01–31, minimum 01. Month range is 01–12, minimum 01. Year range is 00–99, minimum 00.
- EDIT, one action per cycle, in this priority:
  1. programar_on=0: exit to COMMIT. All buttons are ignored this cycle.
  2. up and down events in the same cycle: no action.
  3. up event: field under cursor +1 in BCD. Wrap: day 31→01, month 12→01, year 99→00. Units 9 carry to tens, e.g. 19→20.
  4. down event: field −1 in BCD. Wrap: day 01→31, month 01→12, year 00→99. Units 0 borrow, e.g. 20→19.
  5. left and right events in the same cycle: no action.
  6. right event: cursor 3→4→5→3.
  7. left event: cursor 5→4→3→5.
- A navigation event that coincides with an up or down event is dropped. It is not queued.
- Day validity is not checked against month: 31 is allowed with month 02.
- COMMIT:
  - wr_req=1. fecha_outN is frozen. Cursor = 0.
  - wr_ack=1 while wr_req=1: wr_req <= 0 and state <= IDLE.
  - wr_req stays high indefinitely until ack; there is no timeout.
  - A programar_on rise during COMMIT is not acted on. If programar_on is still 1 on IDLE entry, no rise is seen. It must be dropped and reasserted.
- wr_ack outside COMMIT is ignored.
- busy = (state != IDLE).
- Reset mid-EDIT or mid-COMMIT: return to IDLE immediately, drop wr_req, and discard the edits.

Optional Feature:
- Macro: DATE_EDITOR_AUTOREPEAT_EN.
- When defined:
  - Holding btn_up or btn_down alone in EDIT generates additional up/down events.
  - The first extra event comes after REPEAT_DELAY cycles of continuous hold, then one every REPEAT_PERIOD cycles.
  - The counter clears on release, on a direction change, or on leaving EDIT.
  - Repeat events use the same priority and wrap rules as edge events.
- When undefined: only rising edges act, and no counter logic is synthesised.

Test Plan:
- Reset, then fecha_rtc=31/12/99 -> one cycle later fecha_out=8'h31, 8'h12, 8'h99; cursor=0, wr_req=0, busy=0.
- fecha_rtc=8'h31/8'h12/8'h99, rise programar_on, one btn_up pulse -> cursor=3, day 8'h01; btn_right, btn_up -> month 8'h01; btn_right, btn_up -> year 8'h00.
- Edit, day=8'h01, btn_down -> 8'h31; then day=8'h20, btn_down -> 8'h19; btn_left at cursor 3 -> cursor 5.
- fecha_rtc1=8'h3A, rise programar_on -> day loads 8'h01; fecha_rtc2=8'h00 -> month loads 8'h01.
- btn_up and btn_down rise in the same cycle -> field unchanged; btn_up and btn_right together -> field +1, cursor unchanged.
- Drop programar_on -> wr_req=1 with edited values frozen; hold wr_ack=0 for 10 cycles -> wr_req stays 1; wr_ack=1 -> wr_req=0 next cycle, IDLE, outputs track RTC; reset during COMMIT -> wr_req=0 immediately.
